md_engine: RTL

Parametrised multiply/divide engine for the E stage of the pipelined MIPS core. It holds the HI/LO register pair and runs multiply, divide, multiply-accumulate and move-to-HI/LO operations with independently configurable multiply and divide latencies. It drives `busy` to the hazard logic, which stalls D while `busy` is high. It adds in-flight cancel (`flush`), a completion pulse, and fixed divide-by-zero results.

---
 rtl/md_engine.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/md_engine.sv
// md_engine: multiply/divide engine holding the HI/LO register pair.
//
// Runs mult/multu/div/divu/madd/maddu/msub/msubu and mthi/mtlo. A down-counter
// models the operation latency. The result comes from a combinational datapath
// that sees the latched operands and is written into HI/LO at the completion
// edge.
//
// Ports:
//   clk     - clock; all state updates on its rising edge
//   reset   - synchronous, active-low reset
//   start   - operation request, sampled each rising edge
//   op      - operation select (0 none, 1 mult ... 10 mtlo, 11-15 none)
//   in_a    - rs operand / dividend / mthi-mtlo source
//   in_b    - rt operand / divisor
//   flush   - cancels the in-flight operation
//   rd_sel  - read select: 0 LO, 1 HI
//   rd_data - combinational read of the selected HI/LO register
//   busy    - an operation is in flight
//   done    - one-cycle pulse when HI/LO take a result
//
// state | meaning
// ------+-------------------------------------------------------------
// idle  | cnt == 0; start may be accepted; mthi/mtlo write directly
// busy  | cnt != 0; counting down; the result is written when cnt == 1
module md_engine #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               long_op;
  logic               is_div;

  logic [2*WIDTH-1:0] prod_s, prod_u, acc, result;
  logic [WIDTH-1:0]   mag_a, mag_b, uquot, urem, squot, srem;

  assign busy    = (cnt != '0);
  assign rd_data = rd_sel ? hi : lo;

  assign long_op = (op >= OP_MULT) && (op <= OP_MSUBU);
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign accept  = start && !flush && !busy && long_op;

  // Operands are held only while an operation is pending; no reset needed.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      a_q  <= in_a;
      b_q  <= in_b;
      op_q <= op;
    end
  end

  // Sign-extending to 2*WIDTH before multiplying gives the exact signed product.
  assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign acc    = {hi, lo};

  // Signed divide via magnitudes. |MIN| is representable as an unsigned
  // value, so MIN / -1 falls out as quotient MIN, remainder 0.
  assign mag_a = a_q[WIDTH-1] ? -a_q : a_q;
  assign mag_b = b_q[WIDTH-1] ? -b_q : b_q;
  assign uquot = mag_a / mag_b;
  assign urem  = mag_a % mag_b;
  assign squot = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -uquot : uquot;
  assign srem  = a_q[WIDTH-1] ? -urem : urem;

  always_comb begin
    result = acc;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_MADD:  result = acc + prod_s;
      OP_MADDU: result = acc + prod_u;
      OP_MSUB:  result = acc - prod_s;
      OP_MSUBU: result = acc - prod_u;
      OP_DIV:   result = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {srem, squot};
      OP_DIVU:  result = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {a_q % b_q, a_q / b_q};
      default:  result = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else if (busy) begin
        if (cnt == CW'(1)) begin
          cnt      <= '0;
          {hi, lo} <= result;
          done     <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end else if (start) begin
        if (long_op) begin
          cnt <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (op == OP_MTHI) begin
          hi <= in_a;
        end else if (op == OP_MTLO) begin
          lo <= in_a;
        end
      end
    end
  end

endmodule
